blit_engine: RTL and testbench



---
 rtl/blit_engine.sv | 187 ++++++++++++++++++
 tb/tb_blit_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blit_engine.sv
// blit_engine: rectangle copy from a source memory into the framebuffer,
// with optional colour-key transparency and clipping to framebuffer bounds.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   cmd_valid/ready     command handshake; ready only while idle
//   cmd_src_base        source address of the top-left pixel
//   cmd_src_stride      source words per row
//   cmd_dst_x/y         destination top-left position (unsigned)
//   cmd_width/height    rectangle size in pixels (0 = empty command)
//   cmd_key_en/color    colour-key enable and transparent colour
//   src_address         registered source read address
//   src_r_data          source data, valid combinationally
//   fb_address/w_data   registered framebuffer address and write data
//   fb_w_write          registered framebuffer write strobe
//   busy                command in progress
//   done                one-cycle pulse after the last write
module blit_engine #(
    parameter int WIDTH     = 16,
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240,
    parameter int SRC_DEPTH = 4096,
    parameter int FB_DEPTH  = FB_WIDTH * FB_HEIGHT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [$clog2(SRC_DEPTH)-1:0] cmd_src_base,
    input  logic [$clog2(SRC_DEPTH)-1:0] cmd_src_stride,
    input  logic [15:0]                  cmd_dst_x,
    input  logic [15:0]                  cmd_dst_y,
    input  logic [15:0]                  cmd_width,
    input  logic [15:0]                  cmd_height,
    input  logic                         cmd_key_en,
    input  logic [WIDTH-1:0]             cmd_key_color,
    output logic [$clog2(SRC_DEPTH)-1:0] src_address,
    input  logic [WIDTH-1:0]             src_r_data,
    output logic [$clog2(FB_DEPTH)-1:0]  fb_address,
    output logic [WIDTH-1:0]             fb_w_data,
    output logic                         fb_w_write,
    output logic                         busy,
    output logic                         done
);

    localparam int SAW = $clog2(SRC_DEPTH);
    localparam int FAW = $clog2(FB_DEPTH);
    localparam logic [16:0] X_LIM = 17'(FB_WIDTH);
    localparam logic [16:0] Y_LIM = 17'(FB_HEIGHT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    state_t state_q, state_d;

    logic [15:0]      dst_x_q, dst_y_q;
    logic [15:0]      w_q, h_q;
    logic [SAW-1:0]   stride_q;
    logic             key_en_q;
    logic [WIDTH-1:0] key_q;
    logic [15:0]      row_q, col_q;
    logic [SAW-1:0]   src_row_q;
    logic [FAW-1:0]   fb_row_q, fb_ptr_q;
    // First RUN cycle only sets up the destination pointers; the one
    // multiply needed per command happens there, off the command path.
    logic             prime_q;

    logic [16:0]    x_pos, y_pos;
    logic           col_last, row_last, pix_last;
    logic           in_bounds, keyed, empty_cmd;
    logic [SAW-1:0] src_row_nxt;
    logic [FAW-1:0] fb_row_nxt, fb_start;

    always_comb begin
        x_pos       = {1'b0, dst_x_q} + {1'b0, col_q};
        y_pos       = {1'b0, dst_y_q} + {1'b0, row_q};
        col_last    = (col_q == w_q - 16'd1);
        row_last    = (row_q == h_q - 16'd1);
        pix_last    = col_last && row_last;
        in_bounds   = (x_pos < X_LIM) && (y_pos < Y_LIM);
        keyed       = key_en_q && (src_r_data == key_q);
        empty_cmd   = (cmd_width == 16'd0) || (cmd_height == 16'd0);
        src_row_nxt = src_row_q + stride_q;
        fb_row_nxt  = fb_row_q + FAW'(FB_WIDTH);
        fb_start    = FAW'(32'(dst_y_q) * 32'(FB_WIDTH) + 32'(dst_x_q));
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (cmd_valid) state_d = empty_cmd ? FINISH : RUN;
            RUN:    if (!prime_q && pix_last) state_d = DRAIN;
            DRAIN:  state_d = FINISH;
            FINISH: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dst_x_q     <= '0;
            dst_y_q     <= '0;
            w_q         <= '0;
            h_q         <= '0;
            stride_q    <= '0;
            key_en_q    <= 1'b0;
            key_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            src_row_q   <= '0;
            fb_row_q    <= '0;
            fb_ptr_q    <= '0;
            prime_q     <= 1'b0;
            src_address <= '0;
            fb_address  <= '0;
            fb_w_data   <= '0;
            fb_w_write  <= 1'b0;
        end else begin
            fb_w_write <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        dst_x_q     <= cmd_dst_x;
                        dst_y_q     <= cmd_dst_y;
                        w_q         <= cmd_width;
                        h_q         <= cmd_height;
                        stride_q    <= cmd_src_stride;
                        key_en_q    <= cmd_key_en;
                        key_q       <= cmd_key_color;
                        row_q       <= '0;
                        col_q       <= '0;
                        src_row_q   <= cmd_src_base;
                        src_address <= cmd_src_base;
                        prime_q     <= 1'b1;
                    end
                end
                RUN: begin
                    if (prime_q) begin
                        prime_q  <= 1'b0;
                        fb_row_q <= fb_start;
                        fb_ptr_q <= fb_start;
                    end else begin
                        fb_address <= fb_ptr_q;
                        fb_w_data  <= src_r_data;
                        fb_w_write <= in_bounds && !keyed;
                        if (col_last) begin
                            col_q       <= '0;
                            row_q       <= row_q + 16'd1;
                            src_row_q   <= src_row_nxt;
                            src_address <= src_row_nxt;
                            fb_row_q    <= fb_row_nxt;
                            fb_ptr_q    <= fb_row_nxt;
                        end else begin
                            col_q       <= col_q + 16'd1;
                            src_address <= src_address + SAW'(1);
                            fb_ptr_q    <= fb_ptr_q + FAW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blit_engine.sv
// tb_blit_engine: randomized scoreboard bench for blit_engine.
// Expected writes and done pulses are queued with their cycle stamps.
module tb_blit_engine;

    localparam int WIDTH     = 16;
    localparam int FB_W      = 400;
    localparam int FB_H      = 240;
    localparam int SRC_DEPTH = 4096;
    localparam int FB_DEPTH  = FB_W * FB_H;
    localparam int SAW       = $clog2(SRC_DEPTH);
    localparam int FAW       = $clog2(FB_DEPTH);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [SAW-1:0]   cmd_src_base = '0;
    logic [SAW-1:0]   cmd_src_stride = '0;
    logic [15:0]      cmd_dst_x = '0;
    logic [15:0]      cmd_dst_y = '0;
    logic [15:0]      cmd_width = '0;
    logic [15:0]      cmd_height = '0;
    logic             cmd_key_en = 1'b0;
    logic [WIDTH-1:0] cmd_key_color = '0;
    logic [SAW-1:0]   src_address;
    logic [WIDTH-1:0] src_r_data;
    logic [FAW-1:0]   fb_address;
    logic [WIDTH-1:0] fb_w_data;
    logic             fb_w_write;
    logic             busy;
    logic             done;

    logic [WIDTH-1:0] src_mem [SRC_DEPTH];
    assign src_r_data = src_mem[src_address];

    blit_engine #(
        .WIDTH(WIDTH), .FB_WIDTH(FB_W), .FB_HEIGHT(FB_H),
        .SRC_DEPTH(SRC_DEPTH), .FB_DEPTH(FB_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_base(cmd_src_base), .cmd_src_stride(cmd_src_stride),
        .cmd_dst_x(cmd_dst_x), .cmd_dst_y(cmd_dst_y),
        .cmd_width(cmd_width), .cmd_height(cmd_height),
        .cmd_key_en(cmd_key_en), .cmd_key_color(cmd_key_color),
        .src_address(src_address), .src_r_data(src_r_data),
        .fb_address(fb_address), .fb_w_data(fb_w_data),
        .fb_w_write(fb_w_write), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    int done_count = 0;
    int busy_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every presented write or done pulse is matched against
    // the head of its queue, including the cycle it was due in.
    always @(negedge clk) begin : monitor
        wr_t e;
        int  dc;
        if (busy) busy_total++;
        if (fb_w_write) begin
            wr_count++;
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL write: unexpected addr=%0d data=%0d cyc=%0d",
                         fb_address, fb_w_data, cyc);
            end else begin
                e = exp_wr.pop_front();
                if (e.cyc != cyc || e.addr != int'(fb_address) ||
                    e.data != int'(fb_w_data)) begin
                    errors++;
                    $display("FAIL write: got cyc=%0d addr=%0d data=%0d, want cyc=%0d addr=%0d data=%0d",
                             cyc, fb_address, fb_w_data, e.cyc, e.addr, e.data);
                end
            end
        end
        if (done) begin
            done_count++;
            checks++;
            if (exp_done.size() == 0) begin
                errors++;
                $display("FAIL done: unexpected pulse cyc=%0d", cyc);
            end else begin
                dc = exp_done.pop_front();
                if (dc != cyc) begin
                    errors++;
                    $display("FAIL done: got cyc=%0d want cyc=%0d", cyc, dc);
                end
            end
        end
    end

    // Reference: walk the rectangle pixel by pixel in raster order.
    task automatic model(input int hs, input int base, input int stride,
                         input int dx, input int dy, input int w,
                         input int h, input bit ken, input int kc);
        int s, d, x, y, n;
        if (w == 0 || h == 0) begin
            exp_done.push_back(hs);
        end else begin
            for (int r = 0; r < h; r++) begin
                for (int c = 0; c < w; c++) begin
                    n = r * w + c;
                    s = (base + r * stride + c) % SRC_DEPTH;
                    d = int'(src_mem[s]);
                    x = dx + c;
                    y = dy + r;
                    if (x < FB_W && y < FB_H && !(ken && d == kc))
                        exp_wr.push_back('{hs + 2 + n, y * FB_W + x, d});
                end
            end
            exp_done.push_back(hs + 2 + w * h);
        end
    endtask

    task automatic send(input int base, input int stride, input int dx,
                        input int dy, input int w, input int h,
                        input bit ken, input int kc, output int hs);
        int n;
        @(negedge clk);
        cmd_src_base   = base[SAW-1:0];
        cmd_src_stride = stride[SAW-1:0];
        cmd_dst_x      = dx[15:0];
        cmd_dst_y      = dy[15:0];
        cmd_width      = w[15:0];
        cmd_height     = h[15:0];
        cmd_key_en     = ken;
        cmd_key_color  = kc[WIDTH-1:0];
        cmd_valid      = 1'b1;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL handshake: cmd_ready=%0b want 1 (timeout)", cmd_ready);
        end
        @(posedge clk);
        #1;
        hs = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_count < target && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (done_count < target) begin
            errors++;
            $display("FAIL done_wait: count=%0d want %0d (timeout)",
                     done_count, target);
        end
    endtask

    task automatic run(input int base, input int stride, input int dx,
                       input int dy, input int w, input int h,
                       input bit ken, input int kc, input bit b2b);
        int hs, b0, nd, eb;
        nd = done_count + 1;
        b0 = busy_total;
        send(base, stride, dx, dy, w, h, ken, kc, hs);
        model(hs, base, stride, dx, dy, w, h, ken, kc);
        wait_done(nd);
        if (!b2b) begin
            @(negedge clk);
            #1;
            checks++;
            if (!cmd_ready || busy) begin
                errors++;
                $display("FAIL idle_after: ready=%0b busy=%0b want 1/0",
                         cmd_ready, busy);
            end
            eb = (w == 0 || h == 0) ? 1 : w * h + 3;
            checks++;
            if (busy_total - b0 != eb) begin
                errors++;
                $display("FAIL busy_len: got %0d want %0d",
                         busy_total - b0, eb);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (!cmd_ready || busy || done || fb_w_write ||
            fb_address != '0 || fb_w_data != '0 || src_address != '0) begin
            errors++;
            $display("FAIL %s: ready=%0b busy=%0b done=%0b wr=%0b addr=%0d data=%0d src=%0d want 1/0/0/0/0/0/0",
                     tag, cmd_ready, busy, done, fb_w_write, fb_address,
                     fb_w_data, src_address);
        end
    endtask

    initial begin
        int w0, dx, dy;
        for (int i = 0; i < SRC_DEPTH; i++) src_mem[i] = WIDTH'(i);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        reset = 1'b0;

        // basic copy, colour key, clipping, empty rectangle
        run(0, 4, 10, 2, 4, 2, 1'b0, 0, 1'b0);
        run(0, 4, 10, 2, 4, 2, 1'b1, 5, 1'b0);
        run(0, 4, 398, 239, 4, 3, 1'b0, 0, 1'b0);
        run(0, 4, 10, 2, 0, 5, 1'b0, 0, 1'b0);

        // reset after the third write of a 4x4 command
        begin
            int hs;
            w0 = wr_count;
            send(0, 4, 10, 2, 4, 4, 1'b0, 0, hs);
            model(hs, 0, 4, 10, 2, 4, 4, 1'b0, 0);
            for (int n = 0; n < 100 && wr_count < w0 + 3; n++) begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (wr_count != w0 + 3) begin
                errors++;
                $display("FAIL reset_mid: writes=%0d want 3", wr_count - w0);
            end
            reset = 1'b1;
            exp_wr.delete();
            exp_done.delete();
            repeat (2) @(negedge clk);
            #1;
            check_reset_outputs("reset_mid");
            reset = 1'b0;
            repeat (4) @(negedge clk);
        end

        // back-to-back: second command issued the cycle after done
        run(7, 5, 20, 30, 3, 2, 1'b0, 0, 1'b1);
        run(100, 9, 0, 0, 2, 2, 1'b0, 0, 1'b0);

        // randomized: small pixel alphabet so colour keys hit often
        for (int i = 0; i < SRC_DEPTH; i++)
            src_mem[i] = WIDTH'($urandom_range(0, 7));
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0)
                dx = int'($urandom_range(380, 420));
            else if ($urandom_range(0, 5) == 0)
                dx = int'($urandom_range(65530, 65535));
            else
                dx = int'($urandom_range(0, 399));
            if ($urandom_range(0, 3) == 0)
                dy = int'($urandom_range(230, 250));
            else
                dy = int'($urandom_range(0, 239));
            run(int'($urandom_range(0, SRC_DEPTH - 1)),
                int'($urandom_range(0, SRC_DEPTH - 1)),
                dx, dy,
                int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (exp_wr.size() != 0 || exp_done.size() != 0) begin
            errors++;
            $display("FAIL drain: pending writes=%0d dones=%0d want 0/0",
                     exp_wr.size(), exp_done.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
